// File: rtl/dispense_change.sv
// Greedy coin-change dispenser: four 4-bit coin stocks (10/5/2/1), a Moore
// controller that offers one coin at a time to a hopper and waits for its ack.
module dispense_change (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_en,
    input  logic [1:0] load_sel,
    input  logic [3:0] load_value,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] remaining,
    output logic [5:0] coins_paid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [5:0] MAX_COINS = 6'd60;

    state_t          state_q, state_d;
    logic [3:0][3:0] stock_q, stock_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [5:0]      coins_paid_q, coins_paid_d;
    logic            short_q, short_d;
    logic [1:0]      coin_sel_q, coin_sel_d;

    logic            pick_found;
    logic [1:0]      pick_sel;
    logic [7:0]      issue_value;

    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    coin_value = 8'd10;
            2'd1:    coin_value = 8'd5;
            2'd2:    coin_value = 8'd2;
            default: coin_value = 8'd1;
        endcase
    endfunction

    // State and datapath registers, synchronous reset has priority over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            stock_q      <= '0;
            remaining_q  <= '0;
            coins_paid_q <= '0;
            short_q      <= 1'b0;
            coin_sel_q   <= '0;
        end else begin
            state_q      <= state_d;
            stock_q      <= stock_d;
            remaining_q  <= remaining_d;
            coins_paid_q <= coins_paid_d;
            short_q      <= short_d;
            coin_sel_q   <= coin_sel_d;
        end
    end

    // Greedy choice: largest denomination not above the remainder with stock left
    always_comb begin
        pick_found = 1'b1;
        pick_sel   = '0;
        if (remaining_q >= 8'd10 && stock_q[0] != '0) begin
            pick_sel = 2'd0;
        end else if (remaining_q >= 8'd5 && stock_q[1] != '0) begin
            pick_sel = 2'd1;
        end else if (remaining_q >= 8'd2 && stock_q[2] != '0) begin
            pick_sel = 2'd2;
        end else if (remaining_q >= 8'd1 && stock_q[3] != '0) begin
            pick_sel = 2'd3;
        end else begin
            pick_found = 1'b0;
        end
    end

    // Next-state logic of the payout controller
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SELECT;
            SELECT: begin
                if (remaining_q == '0)  state_d = DONE;
                else if (pick_found)    state_d = ISSUE;
                else                    state_d = DONE;
            end
            ISSUE:   if (coin_ack) state_d = SELECT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: stock loads, payout setup, coin selection and acceptance
    always_comb begin
        stock_d      = stock_q;
        remaining_d  = remaining_q;
        coins_paid_d = coins_paid_q;
        short_d      = short_q;
        coin_sel_d   = coin_sel_q;
        issue_value  = coin_value(coin_sel_q);
        case (state_q)
            IDLE: begin
                // load lands on the same edge as start so SELECT sees it
                if (load_en) stock_d[load_sel] = load_value;
                if (start) begin
                    remaining_d  = amount;
                    coins_paid_d = '0;
                    short_d      = 1'b0;
                end
            end
            SELECT: begin
                if (remaining_q != '0) begin
                    if (pick_found) coin_sel_d = pick_sel;
                    else            short_d    = 1'b1;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    if (remaining_q >= issue_value) remaining_d = remaining_q - issue_value;
                    else                            remaining_d = '0;
                    if (stock_q[coin_sel_q] != '0)
                        stock_d[coin_sel_q] = stock_q[coin_sel_q] - 4'd1;
                    if (coins_paid_q < MAX_COINS)
                        coins_paid_d = coins_paid_q + 6'd1;
                end
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the state register plus registered datapath
    always_comb begin
        coin_valid = (state_q == ISSUE);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        coin_sel   = coin_sel_q;
        short      = short_q;
        remaining  = remaining_q;
        coins_paid = coins_paid_q;
    end

endmodule

// File: tb/tb_dispense_change.sv
// Directed bench for dispense_change: cycle-by-cycle vector tables plus
// hand-written payout sequences for stalls, reset abort and latency.
module tb_dispense_change;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_en = 1'b0;
    logic [1:0] load_sel = '0;
    logic [3:0] load_value = '0;
    logic       start = 1'b0;
    logic [7:0] amount = '0;
    logic       coin_ack = 1'b0;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       short;
    logic [7:0] remaining;
    logic [5:0] coins_paid;

    dispense_change dut (
        .clock      (clock),
        .reset      (reset),
        .load_en    (load_en),
        .load_sel   (load_sel),
        .load_value (load_value),
        .start      (start),
        .amount     (amount),
        .coin_ack   (coin_ack),
        .coin_valid (coin_valid),
        .coin_sel   (coin_sel),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .coins_paid (coins_paid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [1:0] lsel;
        logic [3:0] lval;
        logic       st;
        logic [7:0] amt;
        logic       ack;
        logic       cv;
        logic [1:0] sel;
        logic       bsy;
        logic       dn;
        logic       sh;
        logic [7:0] rem;
        logic [5:0] cp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   pv_done, pv_done_cyc, pv_short, pv_rem, pv_cp, pv_first_valid, pv_ncoins;
    int   pv_seq[8];

    task automatic add(input int rst, input int ld, input int lsel, input int lval,
                       input int st, input int amt, input int ack,
                       input int cv, input int sel, input int bsy, input int dn,
                       input int sh, input int rem, input int cp);
        vec_t v;
        v.rst = rst[0];  v.ld = ld[0];   v.lsel = lsel[1:0]; v.lval = lval[3:0];
        v.st  = st[0];   v.amt = amt[7:0]; v.ack = ack[0];
        v.cv  = cv[0];   v.sel = sel[1:0]; v.bsy = bsy[0]; v.dn = dn[0];
        v.sh  = sh[0];   v.rem = rem[7:0]; v.cp = cp[5:0];
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        logic [19:0] act, exp;
        for (int i = lo; i < hi; i++) begin
            reset = tbl[i].rst; load_en = tbl[i].ld; load_sel = tbl[i].lsel;
            load_value = tbl[i].lval; start = tbl[i].st; amount = tbl[i].amt;
            coin_ack = tbl[i].ack;
            step();
            act = {coin_valid, coin_sel, busy, done, short, remaining, coins_paid};
            exp = {tbl[i].cv, tbl[i].sel, tbl[i].bsy, tbl[i].dn, tbl[i].sh, tbl[i].rem, tbl[i].cp};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got cv=%0d sel=%0d busy=%0d done=%0d short=%0d rem=%0d cp=%0d, expected cv=%0d sel=%0d busy=%0d done=%0d short=%0d rem=%0d cp=%0d",
                         i, coin_valid, coin_sel, busy, done, short, remaining, coins_paid,
                         tbl[i].cv, tbl[i].sel, tbl[i].bsy, tbl[i].dn, tbl[i].sh, tbl[i].rem, tbl[i].cp);
            end
        end
        reset = 1'b0; load_en = 1'b0; start = 1'b0; coin_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input int sel, input int val);
        load_en = 1'b1; load_sel = sel[1:0]; load_value = val[3:0];
        step();
        load_en = 1'b0;
    endtask

    // Start a payout, ack every offer immediately, capture the coin trace and done status
    task automatic do_payout(input int amt);
        int cyc;
        start = 1'b1; amount = amt[7:0];
        step();
        start = 1'b0;
        cyc = 1; pv_done = 0; pv_first_valid = -1; pv_ncoins = 0; pv_done_cyc = -1;
        while (pv_done == 0 && cyc < 300) begin
            if (done) begin
                pv_done = 1; pv_done_cyc = cyc;
                pv_short = short; pv_rem = remaining; pv_cp = coins_paid;
            end else begin
                if (coin_valid) begin
                    if (pv_first_valid < 0) pv_first_valid = cyc;
                    if (pv_ncoins < 8) pv_seq[pv_ncoins] = coin_sel;
                    pv_ncoins++;
                    coin_ack = 1'b1;
                end else begin
                    coin_ack = 1'b0;
                end
                step();
                cyc++;
            end
        end
        coin_ack = 1'b0;
        check("payout_reached_done", pv_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Table A: stock 10:2 5:1 2:3 1:4, pay 18 with every offer acked
        //   rst ld ls lv st amt ack | cv sel bsy dn sh rem cp
        add(1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 0, 2, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 1, 1, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 2, 3, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 3, 4, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 1, 18, 0,   0, 0, 1, 0, 0, 18, 0);
        add(0, 0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 0, 18, 0);
        add(0, 0, 0, 0, 0,  0, 1,   0, 0, 1, 0, 0,  8, 1);
        add(0, 0, 0, 0, 0,  0, 0,   1, 1, 1, 0, 0,  8, 1);
        add(0, 0, 0, 0, 0,  0, 1,   0, 1, 1, 0, 0,  3, 2);
        add(0, 0, 0, 0, 0,  0, 0,   1, 2, 1, 0, 0,  3, 2);
        add(0, 0, 0, 0, 0,  0, 1,   0, 2, 1, 0, 0,  1, 3);
        add(0, 0, 0, 0, 0,  0, 0,   1, 3, 1, 0, 0,  1, 3);
        add(0, 0, 0, 0, 0,  0, 1,   0, 3, 1, 0, 0,  0, 4);
        add(0, 0, 0, 0, 0,  0, 0,   0, 3, 1, 1, 0,  0, 4);
        add(0, 0, 0, 0, 0,  0, 0,   0, 3, 0, 0, 0,  0, 4);
        // Table E: stock 10:1 1:2, pay 12 while start/load are hammered during busy
        add(1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 0, 1, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 3, 2, 0,  0, 0,   0, 0, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 1, 12, 0,   0, 0, 1, 0, 0, 12, 0);
        add(0, 1, 2, 9, 1, 99, 0,   1, 0, 1, 0, 0, 12, 0);
        add(0, 1, 2, 9, 1, 99, 1,   0, 0, 1, 0, 0,  2, 1);
        add(0, 1, 2, 9, 1, 99, 0,   1, 3, 1, 0, 0,  2, 1);
        add(0, 1, 2, 9, 1, 99, 1,   0, 3, 1, 0, 0,  1, 2);
        add(0, 1, 2, 9, 1, 99, 0,   1, 3, 1, 0, 0,  1, 2);
        add(0, 1, 2, 9, 1, 99, 1,   0, 3, 1, 0, 0,  0, 3);
        add(0, 1, 2, 9, 1, 99, 0,   0, 3, 1, 1, 0,  0, 3);
        add(0, 1, 2, 9, 1, 99, 0,   0, 3, 0, 0, 0,  0, 3);
        add(0, 0, 0, 0, 0,  0, 0,   0, 3, 0, 0, 0,  0, 3);

        // Greedy payout of 18 and resulting stock
        run_vectors(0, 16);
        check("A_stock10", dut.stock_q[0], 1);
        check("A_stock5",  dut.stock_q[1], 0);
        check("A_stock2",  dut.stock_q[2], 2);
        check("A_stock1",  dut.stock_q[3], 3);

        // Short payout: 20 from 10:1 5:0 2:2 1:1
        do_reset();
        load(0, 1); load(1, 0); load(2, 2); load(3, 1);
        do_payout(20);
        check("B_first_valid_latency", pv_first_valid, 2);
        check("B_ncoins", pv_ncoins, 4);
        check("B_coin0", pv_seq[0], 0);
        check("B_coin1", pv_seq[1], 2);
        check("B_coin2", pv_seq[2], 2);
        check("B_coin3", pv_seq[3], 3);
        check("B_short", pv_short, 1);
        check("B_remaining", pv_rem, 5);
        check("B_coins_paid", pv_cp, 4);
        for (int i = 0; i < 4; i++) check($sformatf("B_stock%0d", i), dut.stock_q[i], 0);
        step();
        check("B_done_one_cycle", done, 0);
        check("B_idle_after_done", busy, 0);
        check("B_short_held", short, 1);
        check("B_remaining_held", remaining, 5);

        // Hopper stall: ack low for 5 cycles in ISSUE, then a single ack
        do_reset();
        load(1, 3);
        start = 1'b1; amount = 8'd5;
        step();
        start = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("C_stall%0d_valid", k), coin_valid, 1);
            check($sformatf("C_stall%0d_sel", k), coin_sel, 1);
            check($sformatf("C_stall%0d_remaining", k), remaining, 5);
            check($sformatf("C_stall%0d_stock5", k), dut.stock_q[1], 3);
            step();
        end
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        check("C_ack_remaining", remaining, 0);
        check("C_ack_stock5", dut.stock_q[1], 2);
        check("C_ack_coins_paid", coins_paid, 1);
        check("C_ack_valid_drop", coin_valid, 0);
        step();
        check("C_done", done, 1);
        step();
        check("C_stock5_final", dut.stock_q[1], 2);
        check("C_idle", busy, 0);

        // Zero amount goes straight to done with no coin offered
        do_payout(0);
        check("D_done_latency", pv_done_cyc, 2);
        check("D_no_valid", pv_first_valid, -1);
        check("D_coins_paid", pv_cp, 0);
        check("D_short", pv_short, 0);

        // start/load_en ignored while busy
        run_vectors(16, 29);
        check("E_stock10", dut.stock_q[0], 0);
        check("E_stock2",  dut.stock_q[2], 0);
        check("E_stock1",  dut.stock_q[3], 0);

        // Reset during ISSUE beats ack/start/load, then an empty-stock payout
        do_reset();
        load(0, 2); load(1, 1); load(2, 3); load(3, 4);
        start = 1'b1; amount = 8'd18;
        step();
        start = 1'b0;
        step();
        check("F_in_issue", coin_valid, 1);
        reset = 1'b1; coin_ack = 1'b1; start = 1'b1; load_en = 1'b1;
        load_sel = 2'd0; load_value = 4'd15; amount = 8'd18;
        step();
        reset = 1'b0; coin_ack = 1'b0; start = 1'b0; load_en = 1'b0;
        check("F_valid", coin_valid, 0);
        check("F_busy", busy, 0);
        check("F_done", done, 0);
        check("F_short", short, 0);
        check("F_remaining", remaining, 0);
        check("F_coins_paid", coins_paid, 0);
        check("F_coin_sel", coin_sel, 0);
        for (int i = 0; i < 4; i++) check($sformatf("F_stock%0d", i), dut.stock_q[i], 0);
        do_payout(3);
        check("F_empty_short", pv_short, 1);
        check("F_empty_remaining", pv_rem, 3);
        check("F_empty_coins_paid", pv_cp, 0);
        check("F_empty_no_valid", pv_first_valid, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
